// File: rtl/div_unit_if.sv
// Operand/result bundle between the execute stage and the iterative divider.
// The master side issues divisions and collects HI/LO results; the slave is the divider.
interface div_unit_if;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        done;
    logic        busy;
    logic        stall_req;

    modport master (
        output start, signed_div, dividend, divisor, cancel,
        input  quotient, remainder, done, busy, stall_req
    );

    modport slave (
        input  start, signed_div, dividend, divisor, cancel,
        output quotient, remainder, done, busy, stall_req
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU: 32 CALC cycles, one DONE cycle.
// Operates on magnitudes and negates the results on the way into the HI/LO output registers.
module div_unit (
    input  logic        clk,
    input  logic        reset,
    div_unit_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic [4:0]  r_cnt;
    logic        r_qneg;
    logic        r_rneg;
    logic [31:0] r_quotient;
    logic [31:0] r_remainder;

    logic        w_accept;
    logic        w_div_zero;
    logic        w_last;
    logic [31:0] w_dvd_abs;
    logic [31:0] w_dvs_abs;
    logic [32:0] w_rem_sh;
    logic [33:0] w_diff;
    logic        w_borrow;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [31:0] w_quo_final;
    logic [31:0] w_rem_final;

    assign w_accept   = (r_state == S_IDLE) && bus.start && !bus.cancel;
    assign w_div_zero = (bus.divisor == 32'd0);
    assign w_last     = (r_cnt == 5'd31);

    // 0x80000000 negates to itself, which is exactly 2^31 when read as unsigned.
    assign w_dvd_abs = (bus.signed_div && bus.dividend[31]) ? (32'd0 - bus.dividend) : bus.dividend;
    assign w_dvs_abs = (bus.signed_div && bus.divisor[31])  ? (32'd0 - bus.divisor)  : bus.divisor;

    // The shifted remainder keeps its carry bit so divisors >= 2^31 still compare correctly.
    assign w_rem_sh    = {r_rem, r_quo[31]};
    assign w_diff      = {1'b0, w_rem_sh} - {2'b00, r_dvs};
    assign w_borrow    = w_diff[33];
    assign w_rem_next  = w_borrow ? w_rem_sh[31:0] : w_diff[31:0];
    assign w_quo_next  = {r_quo[30:0], ~w_borrow};
    assign w_quo_final = r_qneg ? (32'd0 - w_quo_next) : w_quo_next;
    assign w_rem_final = r_rneg ? (32'd0 - w_rem_next) : w_rem_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_div_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (bus.cancel) begin
                    w_state_next = S_IDLE;
                end else if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.done      = (r_state == S_DONE) && !bus.cancel;
        bus.busy      = (r_state != S_IDLE);
        bus.stall_req = w_accept || (r_state == S_CALC);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem       <= 32'd0;
            r_quo       <= 32'd0;
            r_dvs       <= 32'd0;
            r_cnt       <= 5'd0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_quotient  <= 32'd0;
            r_remainder <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_div_zero) begin
                            r_quotient  <= 32'hFFFF_FFFF;
                            r_remainder <= bus.dividend;
                        end else begin
                            r_rem  <= 32'd0;
                            r_quo  <= w_dvd_abs;
                            r_dvs  <= w_dvs_abs;
                            r_cnt  <= 5'd0;
                            r_qneg <= bus.signed_div && (bus.dividend[31] ^ bus.divisor[31]);
                            r_rneg <= bus.signed_div && bus.dividend[31];
                        end
                    end
                end
                S_CALC: begin
                    if (!bus.cancel) begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + 5'd1;
                        if (w_last) begin
                            r_quotient  <= w_quo_final;
                            r_remainder <= w_rem_final;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against an arithmetic reference model.
// Each division prints one line; every check is an immediate assertion.
module tb_div_unit;
    logic clk;
    logic reset;
    int   total;
    int   passed;

    div_unit_if bus ();

    div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic (truncating division), plus the divide-by-zero rule.
    task automatic model(input logic sd, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            sa = sd ? longint'($signed(a)) : longint'({32'd0, a});
            sb = sd ? longint'($signed(b)) : longint'({32'd0, b});
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endtask

    // Runs one division from cycle 0; spur_at >= 0 injects an ignored start pulse in that cycle.
    task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b, input int spur_at);
        logic [31:0] eq, er, prev_q;
        int done_cyc, stall_cnt, exp_cyc, exp_stall;
        model(sd, a, b, eq, er);
        exp_cyc   = (b == 32'd0) ? 1 : 33;
        exp_stall = (b == 32'd0) ? 1 : 33;
        prev_q    = bus.quotient;
        bus.start = 1'b1; bus.signed_div = sd; bus.dividend = a; bus.divisor = b;
        #1;
        stall_cnt = bus.stall_req ? 1 : 0;
        done_cyc  = -1;
        for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            tick();
            bus.start    = 1'b0;
            bus.dividend = $urandom;
            bus.divisor  = $urandom;
            if (bus.stall_req) stall_cnt++;
            if (bus.done) done_cyc = cyc;
            if (cyc == 5) chk("q_hold_calc", bus.quotient, prev_q);
            if (cyc == spur_at) begin
                bus.start = 1'b1; bus.signed_div = ~sd; bus.divisor = 32'd0;
                #1;
            end
        end
        chk("done_cycle", 32'(done_cyc), 32'(exp_cyc));
        chk("quotient", bus.quotient, eq);
        chk("remainder", bus.remainder, er);
        chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
        tick();
        chk("busy_after", {31'd0, bus.busy}, 32'd0);
        chk("done_after", {31'd0, bus.done}, 32'd0);
        $display("div sd=%0d a=%h b=%h -> q=%h r=%h done@%0d", sd, a, b, bus.quotient, bus.remainder, done_cyc);
    endtask

    initial begin
        logic [31:0] pq, pr, ra, rb;
        int dcnt;
        total  = 0;
        passed = 0;
        reset  = 1'b1;
        bus.start = 1'b0; bus.signed_div = 1'b0; bus.dividend = 32'd0;
        bus.divisor = 32'd0; bus.cancel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_quotient", bus.quotient, 32'd0);
        chk("rst_remainder", bus.remainder, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_stall", {31'd0, bus.stall_req}, 32'd0);
        #1 reset = 1'b0;
        tick();

        do_div(1'b0, 32'd100, 32'd7, -1);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, -1);
        do_div(1'b0, 32'hFFFF_FFF9, 32'd2, -1);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, -1);
        do_div(1'b1, 32'h1234_5678, 32'd0, -1);
        do_div(1'b0, 32'h8000_0000, 32'h8000_0001, -1);

        // Cancel in cycle 10: idle in 11, no done, results untouched.
        pq = bus.quotient; pr = bus.remainder;
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.dividend = 32'd50; bus.divisor = 32'd5;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            tick();
            bus.start = 1'b0;
        end
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        chk("cancel_busy", {31'd0, bus.busy}, 32'd0);
        dcnt = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus.done) dcnt++;
            tick();
        end
        chk("cancel_no_done", 32'(dcnt), 32'd0);
        chk("cancel_q_hold", bus.quotient, pq);
        chk("cancel_r_hold", bus.remainder, pr);
        $display("cancel 50/5 at cycle 10 -> q=%h r=%h done_pulses=%0d", bus.quotient, bus.remainder, dcnt);

        do_div(1'b0, 32'd1000, 32'd7, 20);

        // Asynchronous reset in the middle of cycle 15.
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.dividend = 32'd123456; bus.divisor = 32'd789;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            tick();
            bus.start = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        chk("arst_quotient", bus.quotient, 32'd0);
        chk("arst_remainder", bus.remainder, 32'd0);
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_stall", {31'd0, bus.stall_req}, 32'd0);
        $display("reset mid-calc -> q=%h r=%h busy=%0d", bus.quotient, bus.remainder, bus.busy);
        @(posedge clk);
        #2 reset = 1'b0;
        tick();
        do_div(1'b0, 32'd9, 32'd3, -1);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = rb >> $urandom_range(1, 31);
                2: rb = 32'hFFFF_FFFF;
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            do_div(1'($urandom_range(0, 1)), ra, rb, -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 divider for MIPS DIV/DIVU, sitting beside the execute stage. It takes operands from the ID/EXE register outputs and produces quotient (LO) and remainder (HI) for the HI/LO register file. It raises a stall request that holds the pipeline while a division is in flight.

## Interface
Parameters:
- none (fixed 32-bit datapath)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; returns the block to IDLE immediately
- start  input  1  request a division this cycle; sampled only in IDLE
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- dividend  input  32  rs operand; sampled with start
- divisor  input  32  rt operand; sampled with start
- cancel  input  1  abort the operation in flight (pipeline flush)
- quotient  output  32  result for LO; registered
- remainder  output  32  result for HI; registered
- done  output  1  one-cycle pulse; results valid, write HI/LO
- busy  output  1  state != IDLE
- stall_req  output  1  stall request to the stall controller; combinational

## Operation
- States: IDLE, CALC, DONE.
- IDLE, start=1, divisor!=0:
  - capture |dividend| and |divisor| (raw values if signed_div=0)
  - latch sign flags: quotient negative = signed_div & (dividend[31]^divisor[31]); remainder negative = signed_div & dividend[31]
  - clear 32-bit partial remainder; set counter to 0; go to CALC.
- IDLE, start=1, divisor==0: go directly to DONE with quotient=32'hFFFFFFFF and remainder=dividend (team-defined; MIPS leaves this undefined).
- IDLE, start=0: hold.
- CALC, once per cycle, restoring step:
  - shift {rem, quo} left by 1
  - trial = rem_shifted - divisor_abs, 33-bit
  - if no borrow, rem = trial and quo[0]=1
  - counter++
  - after the 32nd step go to DONE; sign-corrected (two's-complement negate) values load into quotient/remainder on that transition.
- DONE: done=1 for exactly one cycle, then IDLE.
- start while CALC/DONE: ignored.
- cancel=1 in CALC or DONE: next state IDLE; done not asserted; quotient/remainder keep previous values. cancel in IDLE: no effect. cancel and start both high in IDLE: cancel wins, nothing starts.
- Absolute value of 0x80000000 is 0x80000000 treated as unsigned 2^31; the 32-bit magnitude datapath handles it without overflow. Signed 0x80000000 / -1 gives q=0x80000000, r=0.
- stall_req = (state==IDLE & start & ~cancel) | (state==CALC). Low in DONE, so EXE advances in the done cycle and HI/LO captures the result.
- quotient/remainder change only on entry to DONE; otherwise they hold.

## Timing
- Reset values: state IDLE, quotient=0, remainder=0, done=0, busy=0, stall_req=0 (given start=0), internal counter and registers 0.
- Latency, with start high in cycle 0:
  - CALC in cycles 1..32
  - DONE (done=1, results valid) in cycle 33
  - IDLE in cycle 34; a new start is accepted in cycle 34 at the earliest
- Divide-by-zero: DONE in cycle 1.
- stall_req is high in cycles 0..32 and low in cycle 33.
- busy is high in cycles 1..33.
- Reset mid-operation: immediate IDLE, all outputs to reset values, no done pulse.

## Test plan
- DIVU 100/7, start in cycle 0 -> stall_req high cycles 0..32; done only in cycle 33 with quotient=14, remainder=2; busy low in cycle 34.
- DIV -7/2 (0xFFFFFFF9 / 0x00000002) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; DIVU on the same operands -> quotient=0x7FFFFFFC, remainder=1.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0; DIVU 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- Divisor 0, dividend 0x12345678 -> done in cycle 1, quotient=0xFFFFFFFF, remainder=0x12345678.
- cancel in cycle 10 of a DIVU 50/5 -> IDLE in cycle 11; no done pulse; outputs keep prior values. A start pulse in cycle 20 of a following operation is ignored.
- reset asserted asynchronously in cycle 15 mid-CALC -> outputs zero before the next edge. After release, DIVU 9/3 -> done 33 cycles after start, quotient=3, remainder=0.
